instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Multi-cycle fetch stage sitting directly upstream of instruction decode.
- Owns the PC and the instruction register (IR).
- Issues one request/acknowledge read to instruction memory per fetch_start and holds the fetched word stable on `instruction`. Decode is combinational from `instruction`.
- Applies PC updates (sequential or branch) commanded by the control FSM and aborts fetches that are never acknowledged.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles waiting for imem_ack before abort (range 2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- fetch_start  input  1  request one fetch from the current PC.
- pc_write  input  1  load the PC this cycle.
- pc_src  input  1  0: PC <= PC+4; 1: PC <= branch_target.
- branch_target  input  32  branch/jump target address.
- imem_req  output  1  memory read request.
- imem_addr  output  32  memory read address, word-aligned.
- imem_ack  input  1  memory read data valid.
- imem_rdata  input  32  memory read data.
- instruction  output  32  IR contents, feeds decode.
- instr_pc  output  32  address the current IR word was fetched from.
- instr_valid  output  1  one-cycle pulse when a new IR word lands.
- pc  output  32  current PC.
- busy  output  1  fetch in flight.
- fetch_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, immediate on rst_n low):
  - pc = RESET_PC.
  - instruction = 0, instr_pc = 0.
  - imem_req = 0, imem_addr = 0.
  - instr_valid = 0, busy = 0, fetch_err = 0.
  - FSM = IDLE, timeout counter = 0.
- FSM states: IDLE, WAIT.
- IDLE:
  - fetch_start = 1 at an edge → WAIT.
  - At that edge: imem_addr <= pc, imem_req <= 1, busy <= 1, counter <= 0.
- WAIT:
  - imem_req and imem_addr are held constant until exit.
  - imem_ack = 1 at an edge:
    - instruction <= imem_rdata, instr_pc <= imem_addr.
    - instr_valid <= 1 for exactly one cycle.
    - imem_req <= 0, busy <= 0 → IDLE.
  - No ack: counter increments. When counter == TIMEOUT-1 and no ack at that edge:
    - imem_req <= 0, busy <= 0, fetch_err <= 1 for one cycle → IDLE.
    - IR and instr_pc are unchanged.
  - Ack on the same edge the timeout would fire: ack wins, no fetch_err.
- Latency:
  - imem_req rises 1 cycle after fetch_start.
  - A zero-wait memory (ack in the first WAIT cycle) gives instr_valid 2 cycles after fetch_start.
- fetch_start while busy: ignored, no queuing.
- imem_ack while IDLE: ignored, IR unchanged.
- PC update (any state, independent of the FSM):
  - pc_write = 1 at an edge → pc <= pc_src ? {branch_target[31:2], 2'b00} : pc + 4.
  - The in-flight imem_addr is a captured copy, so a PC write during WAIT never disturbs the outstanding request.
  - pc + 4 wraps mod 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
  - Branch target low two bits are silently cleared.
- Same-edge PC write and fetch start in IDLE: imem_addr takes the old pc; pc takes the new value.
- `instruction` is stable between loads.
- Reset mid-fetch: imem_req drops asynchronously, the outstanding transaction is abandoned, and a later ack is ignored.

Test Plan:
1. Reset, then fetch_start pulse with memory ack 1 cycle after req and rdata=32'h00940333:
   - imem_addr=0, imem_req high exactly 1 cycle.
   - instruction=32'h00940333, instr_pc=0, instr_valid single pulse 2 cycles after start.
   - pc stays 0 until pc_write.
2. Sequential fetch: pc_write pc_src=0, then fetch with 3-cycle ack delay and rdata=32'h413903b3:
   - imem_addr=4, req/addr stable all 3 cycles, busy high throughout.
   - instruction=32'h413903b3, instr_pc=4.
3. Branch during WAIT: start fetch at pc=8; while waiting, pc_write pc_src=1 branch_target=32'h0000_0103:
   - imem_addr stays 8, pc becomes 32'h0000_0100.
   - Ack rdata=32'h035a02b3 → instr_pc=8.
4. Timeout with TIMEOUT=16 and no ack:
   - imem_req high 16 cycles, then fetch_err single pulse, busy low.
   - Prior instruction retained.
   - A late ack is ignored.
5. Edge cases:
   - pc=32'hFFFF_FFFC plus pc_write pc_src=0 → pc=0.
   - fetch_start re-pulsed during WAIT → no second request.
   - Ack on the timeout cycle → instr_valid, no fetch_err.
6. Assert rst_n low mid-WAIT:
   - imem_req falls without a clock edge; all outputs take reset values; pc=RESET_PC.
   - A subsequent fetch works normally.

Source files
------------

// File: rtl/instruction_fetch.sv
// Multi-cycle fetch stage: owns PC and IR, issues one req/ack read per fetch_start.
// Ports: clk, rst_n (async low); fetch_start, pc_write, pc_src, branch_target (control);
//        imem_req/imem_addr/imem_ack/imem_rdata (memory); instruction, instr_pc,
//        instr_valid, pc, busy, fetch_err (to decode/control).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instr_pc;
    logic [31:0] r_addr;
    logic        r_req;
    logic        r_valid;
    logic        r_busy;
    logic        r_err;
    logic        w_launch;
    logic        w_done;
    logic        w_abort;
    logic        w_last;
    logic [31:0] w_tgt;

    // Masking keeps every target bit consumed while forcing word alignment.
    assign w_tgt  = branch_target & ~32'h3;
    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (fetch_start)         w_next = S_WAIT;
            S_WAIT: if (imem_ack || w_last)  w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // Ack takes priority over the timeout on the same edge.
    always_comb begin
        w_launch = (r_state == S_IDLE) && fetch_start;
        w_done   = (r_state == S_WAIT) && imem_ack;
        w_abort  = (r_state == S_WAIT) && !imem_ack && w_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= 1'b0;
            r_addr     <= 32'h0;
            r_busy     <= 1'b0;
            r_cnt      <= 8'h0;
            r_ir       <= 32'h0;
            r_instr_pc <= 32'h0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_launch) begin
                r_req  <= 1'b1;
                r_addr <= r_pc;
                r_busy <= 1'b1;
                r_cnt  <= 8'h0;
            end else if (w_done) begin
                r_ir       <= imem_rdata;
                r_instr_pc <= r_addr;
                r_valid    <= 1'b1;
                r_req      <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_abort) begin
                r_req  <= 1'b0;
                r_busy <= 1'b0;
                r_err  <= 1'b1;
                r_cnt  <= 8'h0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // PC runs independently; the request address is a captured copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_pc <= RESET_PC;
        else if (pc_write) r_pc <= pc_src ? w_tgt : r_pc + 32'd4;
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_ir;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign fetch_err   = r_err;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Drives inputs and samples outputs 1ns after each rising edge.
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_err;

    int n_chk = 0;
    int n_err = 0;
    int req_cycles;

    instruction_fetch #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_start(fetch_start), .pc_write(pc_write),
        .pc_src(pc_src), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .pc(pc),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'h0);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_ir"},    instruction, 32'h0);
        chk({tag, "_ipc"},   instr_pc, 32'h0);
        chk({tag, "_vld"},   32'(instr_valid), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_err"},   32'(fetch_err), 32'h0);
        chk({tag, "_pc"},    pc, 32'h0);
    endtask

    task automatic set_pc(input logic src, input logic [31:0] tgt);
        pc_write = 1'b1; pc_src = src; branch_target = tgt;
        tick();
        pc_write = 1'b0; pc_src = 1'b0;
    endtask

    initial begin
        // 1: reset and zero-wait fetch
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_vld0", 32'(instr_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00940333;
        tick();
        imem_ack = 1'b0;
        chk("t1_vld", 32'(instr_valid), 32'h1);
        chk("t1_ir", instruction, 32'h00940333);
        chk("t1_ipc", instr_pc, 32'h0);
        chk("t1_reqlo", 32'(imem_req), 32'h0);
        tick();
        chk("t1_vldlo", 32'(instr_valid), 32'h0);
        chk("t1_pc", pc, 32'h0);

        // 2: sequential PC, 3-cycle ack delay
        set_pc(1'b0, 32'h0);
        chk("t2_pc", pc, 32'h4);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 32'(imem_req), 32'h1);
            chk("t2_addr", imem_addr, 32'h4);
            chk("t2_busy", 32'(busy), 32'h1);
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h413903b3;
        tick();
        imem_ack = 1'b0;
        chk("t2_vld", 32'(instr_valid), 32'h1);
        chk("t2_ir", instruction, 32'h413903b3);
        chk("t2_ipc", instr_pc, 32'h4);
        chk("t2_busy0", 32'(busy), 32'h0);

        // 3: branch while waiting
        set_pc(1'b0, 32'h0);
        chk("t3_pc8", pc, 32'h8);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        set_pc(1'b1, 32'h0000_0103);
        chk("t3_pc", pc, 32'h0000_0100);
        chk("t3_addr", imem_addr, 32'h8);
        chk("t3_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'h035a02b3;
        tick();
        imem_ack = 1'b0;
        chk("t3_ir", instruction, 32'h035a02b3);
        chk("t3_ipc", instr_pc, 32'h8);

        // 4: timeout
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 20 && imem_req; i++) begin
            req_cycles++;
            chk("t4_noerr", 32'(fetch_err), 32'h0);
            tick();
        end
        chk("t4_reqcyc", 32'(req_cycles), 32'd16);
        chk("t4_err", 32'(fetch_err), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_vld", 32'(instr_valid), 32'h0);
        tick();
        chk("t4_errlo", 32'(fetch_err), 32'h0);
        chk("t4_ir", instruction, 32'h035a02b3);
        chk("t4_ipc", instr_pc, 32'h8);
        imem_ack = 1'b1; imem_rdata = 32'hdeadbeef;
        tick();
        imem_ack = 1'b0;
        chk("t4_late_vld", 32'(instr_valid), 32'h0);
        chk("t4_late_ir", instruction, 32'h035a02b3);

        // 5a: branch low bits cleared, PC wrap
        set_pc(1'b1, 32'hFFFF_FFFF);
        chk("t5_align", pc, 32'hFFFF_FFFC);
        set_pc(1'b0, 32'h0);
        chk("t5_wrap", pc, 32'h0);

        // 5b: fetch_start held during WAIT
        set_pc(1'b1, 32'h0000_0040);
        fetch_start = 1'b1;
        tick();
        chk("t5_req", 32'(imem_req), 32'h1);
        chk("t5_addr", imem_addr, 32'h40);
        tick();
        chk("t5_req2", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'h00000013;
        tick();
        imem_ack = 1'b0; fetch_start = 1'b0;
        chk("t5_vld", 32'(instr_valid), 32'h1);
        chk("t5_ipc", instr_pc, 32'h40);
        tick();
        chk("t5_noreq", 32'(imem_req), 32'h0);
        chk("t5_nobusy", 32'(busy), 32'h0);

        // 5c: ack on the timeout edge
        set_pc(1'b1, 32'h0000_0080);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t5c_req", 32'(imem_req), 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'h11111111;
        tick();
        imem_ack = 1'b0;
        chk("t5c_vld", 32'(instr_valid), 32'h1);
        chk("t5c_err", 32'(fetch_err), 32'h0);
        chk("t5c_ir", instruction, 32'h11111111);
        chk("t5c_ipc", instr_pc, 32'h80);

        // 6: async reset mid-WAIT
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t6_req", 32'(imem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t6rst");
        imem_ack = 1'b1; imem_rdata = 32'hcafef00d;
        #3;
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("t6_late_vld", 32'(instr_valid), 32'h0);
        chk("t6_late_ir", instruction, 32'h0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("t6_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00a00093;
        tick();
        imem_ack = 1'b0;
        chk("t6_vld", 32'(instr_valid), 32'h1);
        chk("t6_ir", instruction, 32'h00a00093);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
